// File: rtl/beat_monitor.sv
// Heartbeat receiver: synchronizes an asynchronous square-wave beat,
// measures each half-period in clk cycles and tracks lock / loss.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   beat_in      asynchronous beat input
//   half_period  last measured edge-to-edge interval (clk cycles)
//   period_valid one-cycle pulse when half_period/period_ok update
//   period_ok    last measurement within NOMINAL +/- TOL
//   locked       state is LOCKED (registered)
//   lost         state is LOST (registered)
//   err_count    saturating count of bad edges seen while LOCKED
module beat_monitor #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BEAT_FREQ  = 1,
    parameter int unsigned TOL_PCT    = 10,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        beat_in,
    output logic [31:0] half_period,
    output logic        period_valid,
    output logic        period_ok,
    output logic        locked,
    output logic        lost,
    output logic [7:0]  err_count
);

    // Derived in 64 bits so NOMINAL*TOL_PCT cannot overflow.
    localparam logic [63:0] NOM_W = 64'(CLK_FREQ) / 64'd2 / 64'(BEAT_FREQ);
    localparam logic [63:0] TOL_W = NOM_W * 64'(TOL_PCT) / 64'd100;
    localparam logic [63:0] TO_W  = NOM_W * 64'd2;

    localparam logic [31:0] NOMINAL = NOM_W[31:0];
    localparam logic [31:0] TOL     = TOL_W[31:0];
    localparam logic [31:0] TIMEOUT = TO_W[31:0];
    localparam logic [31:0] LO      = NOMINAL - TOL;
    localparam logic [31:0] HI      = NOMINAL + TOL;
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        LOST
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  good_cnt;
    logic [7:0]  good_nx;
    logic        err_inc;
    logic        locked_d;
    logic        lost_d;

    logic        s1;
    logic        s2;
    logic        s3;
    logic        beat_edge;
    logic [31:0] cnt;
    logic        in_tol;
    logic        measuring;
    logic        at_timeout;

    // s1/s2 form the metastability synchronizer; s3 is the edge reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= beat_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign beat_edge  = s2 ^ s3;
    assign in_tol     = (cnt >= LO) && (cnt <= HI);
    assign at_timeout = (cnt == TIMEOUT);
    assign measuring  = beat_edge && ((state == ACQUIRE) || (state == LOCKED));

    // Restarts at 1 so the value seen at the next edge equals the distance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (beat_edge) begin
            cnt <= 32'd1;
        end else if (cnt < TIMEOUT) begin
            cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_period  <= '0;
            period_ok    <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= measuring;
            if (measuring) begin
                half_period <= cnt;
                period_ok   <= in_tol;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
        end
    end

    // FSM: next state. An edge always takes priority over the timeout.
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_inc  = 1'b0;
        unique case (state)
            IDLE, LOST: begin
                if (beat_edge) begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                end
            end
            ACQUIRE: begin
                if (beat_edge) begin
                    if (in_tol) begin
                        good_nx = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_N) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end else if (at_timeout) begin
                    state_nx = LOST;
                end
            end
            LOCKED: begin
                if (beat_edge) begin
                    if (!in_tol) begin
                        state_nx = ACQUIRE;
                        good_nx  = '0;
                        err_inc  = 1'b1;
                    end
                end else if (at_timeout) begin
                    state_nx = LOST;
                end
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        locked_d = (state == LOCKED);
        lost_d   = (state == LOST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked    <= 1'b0;
            lost      <= 1'b0;
            err_count <= '0;
        end else begin
            locked <= locked_d;
            lost   <= lost_d;
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
